// File: rtl/hub75_bcm_driver.sv
// rtl/hub75_bcm_driver.sv - HUB75 LED-matrix scan driver with binary-coded modulation
//
// Purpose:
//   Reads two pixels per column (upper and lower panel half) from a
//   framebuffer read port, shifts one bit-plane per row into the panel while
//   the previously latched plane is being displayed, then blanks, latches and
//   drives the row address. Plane b of a row is lit for BASE_ON<<b ticks,
//   where one tick is CLK_DIV system clocks.
//
// Optional feature:
//   HUB75_BRIGHTNESS_EN - adds an 8-bit brightness input, sampled when a plane
//   is latched; the lit portion of each plane becomes
//   ((BASE_ON<<p)*(brightness+1))>>8 ticks while the plane period is unchanged.
//
// Ports:
//   clk_27MHz   in   system clock, all logic on the rising edge
//   rst         in   synchronous active-high reset
//   brightness  in   [7:0] global dimming (only with HUB75_BRIGHTNESS_EN)
//   fb_addr     out  {row, column} framebuffer read address
//   fb_data     in   {lower {R,G,B}, upper {R,G,B}}, valid 1 clock after fb_addr
//   rgb1, rgb2  out  upper / lower half serial data {R,G,B}
//   row         out  displayed row address
//   sclk        out  panel shift clock
//   oe          out  output blank, 1 = LEDs off
//   latch       out  panel latch
//   frame_start out  one-clock pulse when row 0 / column 0 / plane 0 is addressed
module hub75_bcm_driver #(
    parameter int COLS          = 64,
    parameter int ROW_ADDR_BITS = 5,
    parameter int COLOR_BITS    = 4,
    parameter int CLK_DIV       = 4,
    parameter int BASE_ON       = 8
) (
    input  logic                                   clk_27MHz,
    input  logic                                   rst,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]                             brightness,
`endif
    output logic [ROW_ADDR_BITS+$clog2(COLS)-1:0]  fb_addr,
    input  logic [6*COLOR_BITS-1:0]                fb_data,
    output logic [2:0]                             rgb1,
    output logic [2:0]                             rgb2,
    output logic [ROW_ADDR_BITS-1:0]               row,
    output logic                                   sclk,
    output logic                                   oe,
    output logic                                   latch,
    output logic                                   frame_start
);

    localparam int COL_W  = $clog2(COLS);
    localparam int AW     = ROW_ADDR_BITS + COL_W;
    localparam int ON_MAX = BASE_ON << (COLOR_BITS - 1);
    localparam int ON_W   = $clog2(ON_MAX + 1);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int PL_W   = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;

    typedef enum logic [2:0] {
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_WAIT,
        ST_BLANK,
        ST_LATCH,
        ST_SHOW
    } state_t;

    state_t                   state_q, state_d;
    logic [DIV_W-1:0]         div_q, div_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [PL_W-1:0]          plane_q, plane_d;
    logic [ROW_ADDR_BITS-1:0] row_cnt_q, row_cnt_d;
    logic [ON_W-1:0]          on_cnt_q, on_cnt_d;
    logic [ON_W-1:0]          off_thr_q, off_thr_d;
    logic [2:0]               rgb1_q, rgb1_d;
    logic [2:0]               rgb2_q, rgb2_d;
    logic [ROW_ADDR_BITS-1:0] row_q, row_d;
    logic                     sclk_q, sclk_d;
    logic                     oe_q, oe_d;
    logic                     latch_q, latch_d;
    logic [AW-1:0]            fb_addr_q, fb_addr_d;
    logic                     frame_start_q, frame_start_d;
    logic                     first_q;

    logic                     tick;
    logic [COL_W-1:0]         col_nxt;
    logic [PL_W-1:0]          plane_nxt;
    logic [ROW_ADDR_BITS-1:0] row_nxt;
    logic [ON_W-1:0]          on_len;
    logic [ON_W-1:0]          off_thr;
    logic [COLOR_BITS-1:0]    r_up, g_up, b_up, r_lo, g_lo, b_lo;

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    assign b_up = fb_data[COLOR_BITS-1:0];
    assign g_up = fb_data[2*COLOR_BITS-1:COLOR_BITS];
    assign r_up = fb_data[3*COLOR_BITS-1:2*COLOR_BITS];
    assign b_lo = fb_data[4*COLOR_BITS-1:3*COLOR_BITS];
    assign g_lo = fb_data[5*COLOR_BITS-1:4*COLOR_BITS];
    assign r_lo = fb_data[6*COLOR_BITS-1:5*COLOR_BITS];

    // Column wraps at COLS, which need not be a power of two.
    assign col_nxt = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);

    // Plane/row that will be shifted after the current one.
    always_comb begin
        plane_nxt = plane_q + PL_W'(1);
        row_nxt   = row_cnt_q;
        if (plane_q == PL_W'(COLOR_BITS - 1)) begin
            plane_nxt = '0;
            row_nxt   = row_cnt_q + ROW_ADDR_BITS'(1);
        end
    end

    // Period of the plane being latched, and the on-counter value at which
    // the LEDs switch off (0 means lit for the whole period).
    always_comb begin
        on_len = ON_W'(BASE_ON) << plane_q;
`ifdef HUB75_BRIGHTNESS_EN
        begin
            logic [ON_W+8:0] on_scaled;
            on_scaled = (ON_W+9)'(on_len) * ((ON_W+9)'(brightness) + (ON_W+9)'(1));
            off_thr   = on_len - ON_W'(on_scaled >> 8);
        end
`else
        off_thr = '0;
`endif
    end

    always_comb begin
        state_d       = state_q;
        div_d         = tick ? '0 : div_q + DIV_W'(1);
        col_d         = col_q;
        plane_d       = plane_q;
        row_cnt_d     = row_cnt_q;
        on_cnt_d      = on_cnt_q;
        off_thr_d     = off_thr_q;
        rgb1_d        = rgb1_q;
        rgb2_d        = rgb2_q;
        row_d         = row_q;
        sclk_d        = sclk_q;
        oe_d          = oe_q;
        latch_d       = latch_q;
        fb_addr_d     = fb_addr_q;
        frame_start_d = first_q;

        if (tick) begin
            case (state_q)
                ST_SHIFT_LO: begin
                    sclk_d    = 1'b0;
                    rgb1_d    = {r_up[plane_q], g_up[plane_q], b_up[plane_q]};
                    rgb2_d    = {r_lo[plane_q], g_lo[plane_q], b_lo[plane_q]};
                    col_d     = col_nxt;
                    fb_addr_d = {row_cnt_q, col_nxt};
                    state_d   = ST_SHIFT_HI;
                end
                ST_SHIFT_HI: begin
                    sclk_d  = 1'b1;
                    // Column index has wrapped back to 0 once all COLS are out.
                    state_d = (col_q == '0) ? ST_WAIT : ST_SHIFT_LO;
                end
                ST_WAIT: begin
                    sclk_d = 1'b0;
                    if (on_cnt_q == '0) begin
                        state_d = ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    oe_d    = 1'b1;
                    state_d = ST_LATCH;
                end
                ST_LATCH: begin
                    latch_d   = 1'b1;
                    row_d     = row_cnt_q;
                    on_cnt_d  = on_len;
                    off_thr_d = off_thr;
                    state_d   = ST_SHOW;
                end
                ST_SHOW: begin
                    latch_d       = 1'b0;
                    oe_d          = (on_cnt_q <= off_thr_q);
                    plane_d       = plane_nxt;
                    row_cnt_d     = row_nxt;
                    col_d         = '0;
                    fb_addr_d     = {row_nxt, COL_W'(0)};
                    frame_start_d = first_q | ((row_nxt == '0) && (plane_nxt == '0));
                    state_d       = ST_SHIFT_LO;
                end
                default: begin
                    state_d = ST_SHIFT_LO;
                end
            endcase

            // The freshly loaded count starts running on the tick after SHOW,
            // so the lit time is exactly the loaded number of ticks.
            if ((on_cnt_q != '0) && (state_q != ST_LATCH) && (state_q != ST_SHOW)) begin
                on_cnt_d = on_cnt_q - ON_W'(1);
                if (on_cnt_d <= off_thr_q) begin
                    oe_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_27MHz) begin
        if (rst) begin
            state_q       <= ST_SHIFT_LO;
            div_q         <= '0;
            col_q         <= '0;
            plane_q       <= '0;
            row_cnt_q     <= '0;
            on_cnt_q      <= '0;
            off_thr_q     <= '0;
            rgb1_q        <= '0;
            rgb2_q        <= '0;
            row_q         <= '1;
            sclk_q        <= 1'b0;
            oe_q          <= 1'b1;
            latch_q       <= 1'b0;
            fb_addr_q     <= '0;
            frame_start_q <= 1'b0;
            first_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            col_q         <= col_d;
            plane_q       <= plane_d;
            row_cnt_q     <= row_cnt_d;
            on_cnt_q      <= on_cnt_d;
            off_thr_q     <= off_thr_d;
            rgb1_q        <= rgb1_d;
            rgb2_q        <= rgb2_d;
            row_q         <= row_d;
            sclk_q        <= sclk_d;
            oe_q          <= oe_d;
            latch_q       <= latch_d;
            fb_addr_q     <= fb_addr_d;
            frame_start_q <= frame_start_d;
            first_q       <= 1'b0;
        end
    end

    assign fb_addr     = fb_addr_q;
    assign rgb1        = rgb1_q;
    assign rgb2        = rgb2_q;
    assign row         = row_q;
    assign sclk        = sclk_q;
    assign oe          = oe_q;
    assign latch       = latch_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// tb/tb_hub75_bcm_driver.sv - self-checking bench for hub75_bcm_driver
module tb_hub75_bcm_driver;

    localparam int COLS = 4;
    localparam int RAB  = 1;
    localparam int CB   = 2;
    localparam int DIV  = 2;
    localparam int BON  = 4;
    localparam int ROWS = 1 << RAB;
    localparam int AW   = RAB + 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      bright = 8'd255;
    logic [AW-1:0]   fb_addr;
    logic [6*CB-1:0] fb_data = '0;
    logic [2:0]      rgb1, rgb2;
    logic [RAB-1:0]  row;
    logic            sclk, oe, latch, frame_start;

    logic [6*CB-1:0] ram [0:(1<<AW)-1];

    always #5 clk = ~clk;

    always @(posedge clk) fb_data <= ram[fb_addr];

    hub75_bcm_driver #(
        .COLS(COLS), .ROW_ADDR_BITS(RAB), .COLOR_BITS(CB), .CLK_DIV(DIV), .BASE_ON(BON)
    ) dut (
        .clk_27MHz  (clk),
        .rst        (rst),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness (bright),
`endif
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .rgb1       (rgb1),
        .rgb2       (rgb2),
        .row        (row),
        .sclk       (sclk),
        .oe         (oe),
        .latch      (latch),
        .frame_start(frame_start)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int exp_rgb(input int pix, input int p);
        return (((pix >> (2*CB + p)) & 1) << 2) | (((pix >> (CB + p)) & 1) << 1) | ((pix >> p) & 1);
    endfunction

    // posedge-side bookkeeping: reset seen at the edge, clocks since release
    logic rst_s = 1'b0;
    int   n_clk = 0;
    always @(posedge clk) begin
        rst_s <= rst;
        n_clk <= rst ? 0 : n_clk + 1;
    end

    logic [12:0] outs, p_outs;
    assign outs = {rgb1, rgb2, row, sclk, oe, latch, fb_addr};
    localparam logic [12:0] RST_OUTS = {3'b000, 3'b000, {RAB{1'b1}}, 1'b0, 1'b1, 1'b0, {AW{1'b0}}};

    // behavioural model state
    bit seen_rst = 0;
    int m_row, m_plane, m_col, disp_plane, exp_x, last_latch_n, low_start;
    int lat_cnt, lat_since_fs, oe_falls, pix;
    bit have_prev, in_low, sr, lr, lf, orise, ofall, exp_fs;
    logic p_sclk, p_oe, p_latch;
    int cap_rgb [8];
    int cap_row [8];
    int cap_low [2];
    int cap_addr[4];
    int n_rgb, n_row, n_low, n_addr;

    always @(negedge clk) begin
        if (rst_s) begin
            seen_rst = 1;
            chk("reset_outputs", outs, RST_OUTS);
            chk("reset_frame_start", frame_start, 0);
            m_row = 0; m_plane = 0; m_col = 0; disp_plane = 0; exp_x = 0;
            lat_cnt = 0; lat_since_fs = 0; oe_falls = 0;
            have_prev = 0; in_low = 0;
            n_rgb = 0; n_row = 0; n_low = 0; n_addr = 0;
            foreach (cap_rgb[i]) cap_rgb[i] = 99;
            foreach (cap_row[i]) cap_row[i] = 99;
            foreach (cap_low[i]) cap_low[i] = 99;
            foreach (cap_addr[i]) cap_addr[i] = 99;
        end else if (seen_rst) begin
            sr    = !p_sclk && sclk;
            lr    = !p_latch && latch;
            lf    = p_latch && !latch;
            orise = !p_oe && oe;
            ofall = p_oe && !oe;

            if ((n_clk % DIV) != 0) chk("tick_align", outs, p_outs);

            if (sr) begin
                if (m_col >= COLS) begin
                    chk("extra_sclk", m_col, COLS - 1);
                end else begin
                    pix = int'(ram[m_row*COLS + m_col]);
                    chk("rgb1", rgb1, exp_rgb(pix, m_plane));
                    chk("rgb2", rgb2, exp_rgb(pix >> (3*CB), m_plane));
                    chk("fb_addr_next", fb_addr, m_row*COLS + (m_col + 1) % COLS);
                    if (n_rgb < 8) begin cap_rgb[n_rgb] = rgb1; n_rgb++; end
                    if (n_addr < 4) begin cap_addr[n_addr] = fb_addr; n_addr++; end
                end
                m_col++;
            end

            if (lr) begin
                chk("sclk_per_latch", m_col, COLS);
                chk("latch_row", row, m_row);
                if (have_prev)
                    chk("latch_period", n_clk - last_latch_n,
                        (((2*COLS > (BON << disp_plane)) ? 2*COLS : (BON << disp_plane)) + 4) * DIV);
                have_prev    = 1;
                last_latch_n = n_clk;
                disp_plane   = m_plane;
                exp_x        = ((BON << m_plane) * (int'(bright) + 1)) >> 8;
                if (n_row < 8) begin cap_row[n_row] = row; n_row++; end
                m_col = 0;
                m_plane++;
                if (m_plane == CB) begin m_plane = 0; m_row = (m_row + 1) % ROWS; end
                lat_cnt++;
                lat_since_fs++;
            end

            if (latch) chk("oe_during_latch", oe, 1);

            if (lf) begin
                chk("oe_at_show", oe, (exp_x == 0) ? 1 : 0);
                low_start = n_clk;
            end
            if (ofall) begin
                chk("oe_fall_at_show", lf, 1);
                oe_falls++;
                in_low = 1;
            end
            if (orise && in_low) begin
                chk("oe_low_len", n_clk - low_start, exp_x * DIV);
                if (n_low < 2) begin cap_low[n_low] = n_clk - low_start; n_low++; end
                in_low = 0;
            end

            exp_fs = (n_clk == 1) || (lf && m_row == 0 && m_plane == 0);
            chk("frame_start", frame_start, exp_fs);
            if (frame_start) begin
                chk("fs_addr", fb_addr, 0);
                if (n_clk != 1) chk("fs_period_latches", lat_since_fs, ROWS*CB);
                lat_since_fs = 0;
            end
        end
        p_outs  = outs;
        p_sclk  = sclk;
        p_oe    = oe;
        p_latch = latch;
    end

    task automatic wait_latches(input int n, input int budget);
        int k = 0;
        while (lat_cnt < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk("wait_latches", (lat_cnt >= n) ? 1 : 0, 1);
    endtask

    task automatic begin_reset();
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic end_reset(input int cyc);
        repeat (cyc) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int exp_rgb_lit [8] = '{0, 0, 0, 0, 4, 0, 0, 0};
    int exp_row_lit [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    int exp_addr_lit[4] = '{1, 2, 3, 0};

    initial begin
        bit found;
        int k;

        // directed: only upper pixel of row 0 / col 0 has R = 2'b10
        foreach (ram[i]) ram[i] = '0;
        ram[0] = 12'h020;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        wait_latches(9, 1000);
        for (int i = 0; i < 8; i++) chk("lit_rgb1_first_planes", cap_rgb[i], exp_rgb_lit[i]);
        for (int i = 0; i < 8; i++) chk("lit_latched_rows", cap_row[i], exp_row_lit[i]);
`ifndef HUB75_BRIGHTNESS_EN
        chk("lit_oe_low_plane0", cap_low[0], 8);
        chk("lit_oe_low_plane1", cap_low[1], 16);
`endif

        // reset pulse during the third SHIFT_HI of row 1
        found = 0;
        k = 0;
        while (!found && k < 1000) begin
            @(posedge clk); #1;
            found = (m_row == 1 && m_col == 2 && sclk == 1'b0);
            k++;
        end
        chk("found_third_shift_hi", found, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_sclk", sclk, 0);
        chk("midrst_oe", oe, 1);
        chk("midrst_row", row, 1);
        rst = 1'b0;
        wait_latches(1, 500);
        for (int i = 0; i < 4; i++) chk("lit_addr_after_reset", cap_addr[i], exp_addr_lit[i]);

`ifdef HUB75_BRIGHTNESS_EN
        begin_reset();
        bright = 8'd127;
        end_reset(2);
        wait_latches(3, 500);
        chk("lit_bright127_plane0", cap_low[0], 4);
        chk("lit_bright127_plane1", cap_low[1], 8);
        begin_reset();
        bright = 8'd0;
        end_reset(2);
        wait_latches(3, 500);
        chk("lit_bright0_no_oe_low", oe_falls, 0);
`endif

        // randomized framebuffer contents and reset points
        for (int ph = 0; ph < 6; ph++) begin
            begin_reset();
            foreach (ram[i]) ram[i] = (6*CB)'($urandom);
`ifdef HUB75_BRIGHTNESS_EN
            bright = 8'($urandom);
`endif
            end_reset($urandom_range(1, 3));
            repeat ($urandom_range(150, 500)) @(posedge clk);
        end

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
